// File: rtl/sonar_pkg.sv
// ----------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the ultrasonic ranging path: the sequencer state
// encoding, the timeout distance code, default timing constants (50 MHz clock)
// and a counter-width helper.
// ----------------------------------------------------------------------------
package sonar_pkg;

    // Sequencer states. S_IDLE must stay at zero: it is the reset state.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_MEASURE   = 3'd3,
        S_RESULT    = 3'd4,
        S_HOLDOFF   = 3'd5
    } sonar_state_t;

    localparam int          DIST_W       = 16;
    localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;

    // Defaults for a 50 MHz clock.
    localparam int DEF_TRIG_CYCLES    = 500;      // 10 us trigger pulse
    localparam int DEF_CYCLES_PER_CM  = 2900;     // echo cycles per cm
    localparam int DEF_ECHO_WAIT_MAX  = 1500000;  // 30 ms echo wait
    localparam int DEF_MAX_CM         = 400;      // largest valid distance
    localparam int DEF_HOLDOFF_CYCLES = 3000000;  // 60 ms between pings

    // Width of a counter that must hold 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sonar_ranging_ctrl_if.sv
// ----------------------------------------------------------------------------
// sonar_ranging_ctrl_if
// Result channel from the ranging sequencer to its consumer.
//   dist_valid : result available (producer)
//   dist_ready : consumer accepts (consumer)
//   dist_cm    : distance in cm, DIST_TIMEOUT when no usable echo (producer)
//   timeout    : 1 = no echo / out of range, qualifies dist_cm (producer)
//   overrun    : 1-cycle pulse, a new result replaced an unaccepted one
//
// Handshake: a transfer happens on every clock edge where dist_valid and
// dist_ready are both 1. While dist_valid is 1 and no transfer has happened,
// dist_cm and timeout do not change, except that the producer may replace an
// unaccepted result with a newer one (flagged by overrun). dist_ready may be
// asserted at any time and does not depend on dist_valid.
// ----------------------------------------------------------------------------
interface sonar_ranging_ctrl_if;
    import sonar_pkg::*;

    logic              dist_valid;
    logic              dist_ready;
    logic [DIST_W-1:0] dist_cm;
    logic              timeout;
    logic              overrun;

    modport master (
        output dist_valid,
        output dist_cm,
        output timeout,
        output overrun,
        input  dist_ready
    );

    modport slave (
        input  dist_valid,
        input  dist_cm,
        input  timeout,
        input  overrun,
        output dist_ready
    );

endinterface

// File: rtl/sonar_echo_sync.sv
// ----------------------------------------------------------------------------
// sonar_echo_sync
// Brings the asynchronous sensor echo into the clk domain through two flops
// and produces single-cycle edge pulses of the synchronized level.
//   clk       in  : system clock
//   reset     in  : asynchronous, active-low
//   echo      in  : raw sensor echo
//   echo_rise out : 1 for the first cycle the synchronized echo is high
//   echo_fall out : 1 for the first cycle the synchronized echo is low
// ----------------------------------------------------------------------------
module sonar_echo_sync
    import sonar_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic echo,
    output logic echo_rise,
    output logic echo_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;   // synchronized level one cycle ago, for edge detect

    always_comb begin
        meta_d = echo;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign echo_rise = sync_q & ~prev_q;
    assign echo_fall = ~sync_q & prev_q;

endmodule

// File: rtl/sonar_ranging_ctrl.sv
// ----------------------------------------------------------------------------
// sonar_ranging_ctrl
// Sequencer for an HC-SR04-style ultrasonic ranger. Fires a trigger pulse on
// request (start) or continuously (auto_en), times the echo pulse with a
// timeout, converts the width to whole cm and offers the result on a
// valid/ready channel.
//   clk       in  : system clock
//   reset     in  : asynchronous, active-low
//   start     in  : single-shot request, only looked at in S_IDLE
//   auto_en   in  : 1 = start a new measurement whenever idle
//   echo      in  : raw (asynchronous) sensor echo
//   trigger   out : sensor trigger pulse
//   busy      out : 1 whenever the sequencer is not idle
//   state_dbg out : current sequencer state
//   dist_if       : result channel (master side)
// ----------------------------------------------------------------------------
module sonar_ranging_ctrl
    import sonar_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
    parameter int ECHO_WAIT_MAX  = DEF_ECHO_WAIT_MAX,
    parameter int MAX_CM         = DEF_MAX_CM,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        auto_en,
    input  logic                        echo,
    output logic                        trigger,
    output logic                        busy,
    output sonar_state_t                state_dbg,
    sonar_ranging_ctrl_if.master        dist_if
);

    localparam int TRIG_W = cnt_width(TRIG_CYCLES);
    localparam int PRE_W  = cnt_width(CYCLES_PER_CM);
    localparam int WAIT_W = cnt_width(ECHO_WAIT_MAX);
    localparam int HOLD_W = cnt_width(HOLDOFF_CYCLES);

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYCLES_PER_CM - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ECHO_WAIT_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [DIST_W-1:0] CM_LIMIT  = DIST_W'(MAX_CM);

    // The rising-edge cycle is itself the first echo-high cycle, so the
    // prescaler is already one count in when MEASURE is entered.
    localparam logic [PRE_W-1:0]  PRE_START = (CYCLES_PER_CM > 1) ? PRE_W'(1) : '0;
    localparam logic [DIST_W-1:0] CM_START  = (CYCLES_PER_CM > 1) ? '0 : DIST_W'(1);

    logic echo_rise, echo_fall;

    sonar_echo_sync u_echo_sync (
        .clk       (clk),
        .reset     (reset),
        .echo      (echo),
        .echo_rise (echo_rise),
        .echo_fall (echo_fall)
    );

    sonar_state_t      state_q,    state_d;
    logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [PRE_W-1:0]  pre_q,      pre_d;
    logic [DIST_W-1:0] cm_q,       cm_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              res_to_q,   res_to_d;   // pending result is a timeout
    logic              trigger_q,  trigger_d;
    logic              busy_q,     busy_d;
    logic              valid_q,    valid_d;
    logic [DIST_W-1:0] dist_q,     dist_d;
    logic              to_q,       to_d;
    logic              overrun_q,  overrun_d;

    logic accept;
    assign accept = valid_q & dist_if.dist_ready;

    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pre_d      = pre_q;
        cm_d       = cm_q;
        hold_cnt_d = hold_cnt_q;
        res_to_d   = res_to_q;
        trigger_d  = trigger_q;
        valid_d    = valid_q;
        dist_d     = dist_q;
        to_d       = to_q;
        overrun_d  = 1'b0;

        if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start || auto_en) begin
                    state_d    = S_TRIG;
                    trig_cnt_d = '0;
                    trigger_d  = 1'b1;
                    res_to_d   = 1'b0;
                end
            end

            S_TRIG: begin
                if (trig_cnt_q == TRIG_LAST) begin
                    trigger_d  = 1'b0;
                    state_d    = S_WAIT_ECHO;
                    wait_cnt_d = '0;
                end else begin
                    trig_cnt_d = trig_cnt_q + TRIG_W'(1);
                end
            end

            S_WAIT_ECHO: begin
                // Only a 0->1 transition counts; a level already high on
                // entry never produces echo_rise here.
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    pre_d   = PRE_START;
                    cm_d    = CM_START;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = S_RESULT;
                    res_to_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_MEASURE: begin
                if (echo_fall) begin
                    state_d  = S_RESULT;
                    res_to_d = 1'b0;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    // Another whole cm would pass the range limit: give up
                    // now instead of waiting for the echo to end.
                    if (cm_q == CM_LIMIT) begin
                        state_d  = S_RESULT;
                        res_to_d = 1'b1;
                    end else begin
                        cm_d = cm_q + DIST_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end

            S_RESULT: begin
                // A new load overrides a same-cycle acceptance.
                dist_d     = res_to_q ? DIST_TIMEOUT : cm_q;
                to_d       = res_to_q;
                valid_d    = 1'b1;
                overrun_d  = valid_q & ~dist_if.dist_ready;
                state_d    = S_HOLDOFF;
                hold_cnt_d = '0;
            end

            S_HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                trigger_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            trig_cnt_q <= '0;
            wait_cnt_q <= '0;
            pre_q      <= '0;
            cm_q       <= '0;
            hold_cnt_q <= '0;
            res_to_q   <= 1'b0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            dist_q     <= '0;
            to_q       <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_cnt_q <= trig_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pre_q      <= pre_d;
            cm_q       <= cm_d;
            hold_cnt_q <= hold_cnt_d;
            res_to_q   <= res_to_d;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            dist_q     <= dist_d;
            to_q       <= to_d;
            overrun_q  <= overrun_d;
        end
    end

    assign trigger            = trigger_q;
    assign busy               = busy_q;
    assign state_dbg          = state_q;
    assign dist_if.dist_valid = valid_q;
    assign dist_if.dist_cm    = dist_q;
    assign dist_if.timeout    = to_q;
    assign dist_if.overrun    = overrun_q;

endmodule

// File: tb/tb_sonar_ranging_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sonar_ranging_ctrl
// Self-checking bench for sonar_ranging_ctrl with small timing parameters.
// A background sensor responder answers each trigger with a planned echo;
// expected results come from a transaction-level model of the ranging rules.
// ----------------------------------------------------------------------------
module tb_sonar_ranging_ctrl;
    import sonar_pkg::*;

    localparam int TRIG  = 10;
    localparam int CPC   = 29;
    localparam int WMAX  = 200;
    localparam int MAXCM = 20;
    localparam int HOLD  = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic auto_en = 1'b0;
    logic echo = 1'b0;
    logic trigger, busy;
    sonar_state_t state_dbg;

    sonar_ranging_ctrl_if dist_if();

    always #5 clk = ~clk;

    sonar_ranging_ctrl #(
        .TRIG_CYCLES   (TRIG),
        .CYCLES_PER_CM (CPC),
        .ECHO_WAIT_MAX (WMAX),
        .MAX_CM        (MAXCM),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .auto_en  (auto_en),
        .echo     (echo),
        .trigger  (trigger),
        .busy     (busy),
        .state_dbg(state_dbg),
        .dist_if  (dist_if.master)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        bit early;       // echo already high before the trigger ends
        int early_fall;  // cycles after trigger fall that early level drops
        int delay;       // cycles before the real echo rises
        int width;       // echo high cycles, 0 = no echo at all
    } plan_t;

    plan_t       plan_q[$];
    logic [16:0] exp_q[$];   // {timeout, dist_cm}
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole cm of echo, partial cm dropped; no echo or beyond range = timeout.
    function automatic logic [16:0] model(input plan_t p);
        int cm;
        if (p.width == 0) return {1'b1, DIST_TIMEOUT};
        cm = p.width / CPC;
        if (cm > MAXCM) return {1'b1, DIST_TIMEOUT};
        return {1'b0, 16'(cm)};
    endfunction

    task automatic add_plan(input bit early, input int ef, input int d, input int w);
        plan_t p;
        p.early = early;
        p.early_fall = ef;
        p.delay = d;
        p.width = w;
        plan_q.push_back(p);
        exp_q.push_back(model(p));
    endtask

    // ---------------- sensor responder ----------------
    initial begin : responder
        plan_t p;
        int    tw;
        bit    have;
        forever begin
            @(negedge clk);
            if (trigger) begin
                tw = 0;
                have = (plan_q.size() > 0);
                if (have) p = plan_q.pop_front();
                while (trigger) begin
                    tw++;
                    if (have && p.early && tw == 3) echo = 1'b1;
                    @(negedge clk);
                end
                check_eq("trig_width", tw, TRIG);
                if (have) begin
                    if (p.early) begin
                        repeat (p.early_fall) @(negedge clk);
                        echo = 1'b0;
                    end
                    if (p.width > 0) begin
                        repeat (p.delay) @(negedge clk);
                        echo = 1'b1;
                        repeat (p.width) @(negedge clk);
                        echo = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_trig_rise"}, trigger, 1);
        check_eq({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (dist_if.dist_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq({tag, "_valid_wait"}, 0, 1);
    endtask

    task automatic check_result(input string tag, output logic [16:0] e);
        wait_valid(tag);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0_DEAD;
        check_eq({tag, "_valid"}, dist_if.dist_valid, 1);
        check_eq({tag, "_cm"}, dist_if.dist_cm, e[15:0]);
        check_eq({tag, "_timeout"}, dist_if.timeout, e[16]);
    endtask

    task automatic accept(input string tag, input logic [16:0] e, input int hold);
        repeat (hold) @(negedge clk);
        check_eq({tag, "_held_valid"}, dist_if.dist_valid, 1);
        check_eq({tag, "_held_cm"}, dist_if.dist_cm, e[15:0]);
        dist_if.dist_ready = 1'b1;
        @(negedge clk);
        dist_if.dist_ready = 1'b0;
        check_eq({tag, "_cleared"}, dist_if.dist_valid, 0);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && !echo) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq({tag, "_idle_wait"}, 0, 1);
    endtask

    task automatic one_shot(input string tag, input bit early, input int ef,
                            input int d, input int w, input int hold);
        logic [16:0] e;
        add_plan(early, ef, d, w);
        pulse_start(tag);
        check_result(tag, e);
        accept(tag, e, hold);
        wait_idle(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [16:0] e;
        int j_rise;
        bit seen;
        int bw[4];
        dist_if.dist_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_trigger", trigger, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", dist_if.dist_valid, 0);
        check_eq("rst_cm", dist_if.dist_cm, 0);
        check_eq("rst_timeout", dist_if.timeout, 0);
        check_eq("rst_overrun", dist_if.overrun, 0);
        check_eq("rst_state", state_dbg, S_IDLE);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 290 echo cycles -> 10 cm, held until accepted
        one_shot("t1", 0, 0, 5, 290, 20);

        // no echo -> timeout, then holdoff blocks a held start
        add_plan(0, 0, 0, 0);
        pulse_start("t2");
        check_result("t2", e);
        add_plan(0, 0, 3, 145);
        start = 1'b1;
        j_rise = -1;
        for (int j = 0; j < 80; j++) begin
            dist_if.dist_ready = (j == 0);
            if (trigger) begin
                j_rise = j;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        dist_if.dist_ready = 1'b0;
        check_eq("t2_holdoff", j_rise, HOLD + 1);
        check_result("t2b", e);
        accept("t2b", e, 2);
        wait_idle("t2b");

        // echo too long -> timeout before the echo ends
        add_plan(0, 0, 10, 700);
        pulse_start("t3");
        check_result("t3", e);
        check_eq("t3_echo_still_high", echo, 1);
        accept("t3", e, 1);
        wait_idle("t3");

        // range and rounding boundaries
        bw = '{608, 609, 28, 29};
        foreach (bw[k]) one_shot($sformatf("bnd%0d", bw[k]), 0, 0, 4, bw[k], 0);

        // free-running with no consumer: overrun, then load+accept together
        add_plan(0, 0, 4, 58);
        add_plan(0, 0, 4, 58);
        add_plan(0, 0, 4, 58);
        auto_en = 1'b1;
        check_result("t4a", e);
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (dist_if.overrun) begin
                seen = 1;
                break;
            end
        end
        check_eq("t4_overrun", seen, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0_DEAD;
        check_eq("t4b_cm", dist_if.dist_cm, e[15:0]);
        check_eq("t4b_valid", dist_if.dist_valid, 1);
        @(negedge clk);
        check_eq("t4_overrun_width", dist_if.overrun, 0);
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            if (state_dbg == S_RESULT) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("t4_third_result", seen, 1);
        dist_if.dist_ready = 1'b1;
        auto_en = 1'b0;
        @(negedge clk);
        dist_if.dist_ready = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0_DEAD;
        check_eq("t4c_no_overrun", dist_if.overrun, 0);
        check_eq("t4c_valid", dist_if.dist_valid, 1);
        check_eq("t4c_cm", dist_if.dist_cm, e[15:0]);
        accept("t4c", e, 0);
        repeat (HOLD + 20) @(negedge clk);
        check_eq("t4_rest_busy", busy, 0);
        check_eq("t4_rest_state", state_dbg, S_IDLE);

        // echo already high when waiting starts, real echo 87 -> 3 cm
        one_shot("t5", 1, 5, 30, 87, 3);

        // reset during MEASURE, then a clean measurement
        add_plan(0, 0, 5, 290);
        pulse_start("t6");
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            if (state_dbg == S_MEASURE) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("t6_in_measure", seen, 1);
        repeat (50) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_trigger", trigger, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_valid", dist_if.dist_valid, 0);
        check_eq("t6_rst_cm", dist_if.dist_cm, 0);
        check_eq("t6_rst_timeout", dist_if.timeout, 0);
        check_eq("t6_rst_state", state_dbg, S_IDLE);
        void'(exp_q.pop_front());
        for (int i = 0; i < 1000 && echo; i++) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        one_shot("t6b", 0, 0, 7, 116, 2);

        // randomized measurements
        for (int r = 0; r < 10; r++) begin
            one_shot($sformatf("rnd%0d", r), 0, 0, $urandom_range(0, 120),
                     $urandom_range(0, 700), $urandom_range(0, 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
